// File: rtl/tick_timer_arbiter.sv
// Purpose: shares one prescaled 1 Hz down-counter among 4 requesters, round-robin.
// Latency: grant rises one edge after an IDLE sample of req, lasts dur*TICK_DIV cycles, done on the falling edge.
// Backpressure: requesters hold req until done; dropping req[owner] aborts, non-owners wait for IDLE.
module tick_timer_arbiter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DUR_W    = 8
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_50mhz,
    input  logic [3:0]           req,
    input  logic [4*DUR_W-1:0]   dur,
    output logic [3:0]           grant,
    output logic [3:0]           done,
    output logic                 tick_1hz,
    output logic                 busy,
    output logic [DUR_W-1:0]     remaining
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    prescaler;
    logic [1:0]       last_owner;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic [DUR_W-1:0] win_dur;

    // Round-robin pick: scan from farthest (last_owner itself) to nearest so the
    // nearest requester after last_owner is the final, winning assignment.
    always_comb begin
        winner = last_owner;
        cand   = last_owner;
        for (int k = 4; k >= 1; k--) begin
            cand = last_owner + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
        win_dur = dur[winner*DUR_W +: DUR_W];
    end

    // Timer FSM: arbitrate in IDLE, count prescaled ticks in RUN, one dead cycle in DONE.
    always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
        if (!rst_50mhz) begin
            state      <= S_IDLE;
            prescaler  <= '0;
            last_owner <= 2'd3;
            grant      <= '0;
            done       <= '0;
            tick_1hz   <= 1'b0;
            busy       <= 1'b0;
            remaining  <= '0;
        end else begin
            done     <= '0;
            tick_1hz <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        remaining  <= win_dur;
                        prescaler  <= '0;
                        last_owner <= winner;
                        busy       <= 1'b1;
                        if (win_dur != '0) begin
                            grant <= 4'b0001 << winner;
                            state <= S_RUN;
                        end else begin
                            // Zero-length request completes without ever owning the timer.
                            done  <= 4'b0001 << winner;
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (!req[last_owner]) begin
                        // Owner withdrew: abort wins over a coincident wrap, no done, no tick.
                        grant     <= '0;
                        remaining <= '0;
                        prescaler <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (prescaler == PMAX) begin
                        prescaler <= '0;
                        tick_1hz  <= 1'b1;
                        remaining <= remaining - DUR_W'(1);
                        if (remaining == DUR_W'(1)) begin
                            grant <= '0;
                            done  <= 4'b0001 << last_owner;
                            state <= S_DONE;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                S_DONE: begin
                    remaining <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    grant     <= '0;
                    remaining <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Purpose: scoreboard bench for tick_timer_arbiter with TICK_DIV=5, DUR_W=8.
// Latency: expected grant/tick/busy profiles are queued at stimulus time, compared at done or abort.
// Backpressure: requests are held until their done pulse, then dropped by the driver.
module tb_tick_timer_arbiter;

    localparam int TD = 5;
    localparam int DW = 8;

    logic            clk_50mhz;
    logic            rst_50mhz;
    logic [3:0]      req;
    logic [4*DW-1:0] dur;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic            tick_1hz;
    logic            busy;
    logic [DW-1:0]   remaining;

    tick_timer_arbiter #(.TICK_DIV(TD), .DUR_W(DW)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_50mhz (rst_50mhz),
        .req       (req),
        .dur       (dur),
        .grant     (grant),
        .done      (done),
        .tick_1hz  (tick_1hz),
        .busy      (busy),
        .remaining (remaining)
    );

    initial begin
        clk_50mhz = 1'b0;
        forever #10 clk_50mhz = ~clk_50mhz;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // kind 0 = done completion, 1 = abort (grant fell without done)
    typedef struct {
        int kind;
        int idx;
        int glen;
        int ticks;
        int ftick;
        int bcnt;
    } ev_t;

    ev_t sb[$];

    task automatic push(input int kind, input int idx, input int glen,
                        input int ticks, input int ftick, input int bcnt);
        ev_t e;
        e.kind = kind; e.idx = idx; e.glen = glen;
        e.ticks = ticks; e.ftick = ftick; e.bcnt = bcnt;
        sb.push_back(e);
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: measure each grant episode and compare against the queued expectation.
    int         gcnt, tcnt, ftk, bcnt_m;
    logic [3:0] prev_grant;

    always @(negedge clk_50mhz) begin
        if (!rst_50mhz) begin
            gcnt = 0; tcnt = 0; ftk = -1; bcnt_m = 0; prev_grant = '0;
        end else begin
            ev_t e;
            int  kind, idx;
            chk("grant_onehot", int'($onehot0(grant)), 1);
            if (tick_1hz) begin
                tcnt++;
                if (ftk < 0) ftk = gcnt;
            end
            if (grant != '0) gcnt++;
            if (busy) bcnt_m++;
            if (done != '0 || (prev_grant != '0 && grant == '0)) begin
                kind = (done != '0) ? 0 : 1;
                idx  = (done != '0) ? idx_of(done) : idx_of(prev_grant);
                chk("done_onehot", int'($onehot0(done)), 1);
                chk("rem_at_end", int'(remaining), 0);
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_idx", idx, e.idx);
                    chk("grant_len", gcnt, e.glen);
                    chk("tick_cnt", tcnt, e.ticks);
                    chk("first_tick", ftk, e.ftick);
                    chk("busy_len", bcnt_m, e.bcnt);
                end
                gcnt = 0; tcnt = 0; ftk = -1; bcnt_m = 0;
            end
            prev_grant = grant;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    // Drop each request as soon as its done pulse is seen; bounded.
    task automatic serve(input int budget);
        for (int c = 0; c < budget && req != '0; c++) begin
            @(negedge clk_50mhz);
            req = req & ~done;
        end
        if (req != '0) begin
            chk("serve_timeout", int'(req), 0);
            req = '0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_tick"}, int'(tick_1hz), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rem"}, int'(remaining), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_50mhz = 1'b0;
        req = '0;
        dur = '0;
        #5;
        chk_zero("reset");
        cyc(2);
        rst_50mhz = 1'b1;

        // 1: reset mid-stream, then idle stays idle
        dur[0*DW +: DW] = 8'd5;
        req = 4'b0001;
        cyc(4);
        rst_50mhz = 1'b0;
        #1;
        chk_zero("rst_mid");
        req = '0;
        cyc(2);
        rst_50mhz = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("idle_busy", int'(busy), 0);
        end

        // 3: all four requesters, dur=1 each, round-robin from last_owner=3
        for (int i = 0; i < 4; i++) begin
            dur[i*DW +: DW] = 8'd1;
            push(0, i, TD, 1, TD, TD + 1);
        end
        req = 4'b1111;
        serve(200);

        // 2: single request, 3 ticks
        dur[0*DW +: DW] = 8'd3;
        push(0, 0, 3*TD, 3, TD, 3*TD + 1);
        req = 4'b0001;
        serve(200);

        // 4: zero-duration request
        dur[2*DW +: DW] = 8'd0;
        push(0, 2, 0, 0, -1, 1);
        req = 4'b0100;
        serve(20);

        // 5: abort of requester 1 on grant cycle 7, pending requester 3 takes over
        dur[1*DW +: DW] = 8'd4;
        dur[3*DW +: DW] = 8'd2;
        push(1, 1, 7, 1, TD, 7);
        push(0, 3, 2*TD, 2, TD, 2*TD + 1);
        req = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            cyc(1);
            ok = grant[1];
        end
        chk("abort_grant_seen", int'(ok), 1);
        req[3] = 1'b1;
        cyc(6);
        req[1] = 1'b0;
        serve(100);

        // 6: reset mid-RUN at remaining=2, then a fresh request restarts the prescaler
        dur[0*DW +: DW] = 8'd3;
        req = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            cyc(1);
            ok = (remaining == 8'd2);
        end
        chk("rem2_seen", int'(ok), 1);
        rst_50mhz = 1'b0;
        #1;
        chk_zero("rst_run");
        req = '0;
        cyc(2);
        rst_50mhz = 1'b1;
        dur[0*DW +: DW] = 8'd1;
        push(0, 0, TD, 1, TD, TD + 1);
        req = 4'b0001;
        serve(50);

        cyc(5);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
